icache_responder: RTL
=====================

# icache_responder

Read-only, direct-mapped instruction cache that is the responding end of the fetch stage's instruction-memory port. It accepts word reads (`read_a`/`address_a`) and returns `rdata_a` with a one-cycle `resp_a` pulse. Misses are served by 256-bit line reads from the physical-memory bus. It sits between the fetch stage and the memory arbiter.

## Interface
Parameters:
- `S_INDEX`, 3: log2 of set count (8 sets); line size fixed at 32 bytes.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `read_a`  in  1  fetch read request; held high until `resp_a`.
- `address_a`  in  32  byte address (`rv32i_word`); bits [1:0] ignored.
- `rdata_a`  out  32  instruction word; valid only while `resp_a`=1.
- `resp_a`  out  1  single-cycle response pulse.
- `pmem_read`  out  1  line read request to physical memory.
- `pmem_address`  out  32  line-aligned address, bits [4:0]=0.
- `pmem_rdata`  in  256  line data; valid in the `pmem_resp` cycle.
- `pmem_resp`  in  1  single-cycle line-read completion.

## Operation
- Address split: offset [4:0], word select [4:2], index [4+S_INDEX:5], tag [31:5+S_INDEX].
- Per set: valid bit, tag, and 256-bit line. Word k of the line is `line[32k+31:32k]`.
- An internal `addr_q` register captures `address_a` when a request is accepted in IDLE. All later lookup and fill use `addr_q`. Changing `address_a` mid-request is a protocol violation; the response still returns data for `addr_q`.
- FSM states: IDLE, FILL, RESPOND.
  - IDLE, `read_a`=0: stay in IDLE.
  - IDLE, `read_a`=1, hit (valid && tag match): go to RESPOND.
  - IDLE, `read_a`=1, miss: go to FILL.
  - FILL: `pmem_read`=1 and `pmem_address`={`addr_q`[31:5],5'b0}. On `pmem_resp`, write the line, set the tag, set valid, and go to RESPOND.
  - RESPOND: if `read_a`=1, then `resp_a`=1 and `rdata_a`=selected word. If `read_a`=0, no pulse. Go to IDLE unconditionally.
- If `read_a` drops during FILL, the fill still completes and the line is installed; no response pulse is issued.
- Conflict miss (valid set, different tag): the line is overwritten with no writeback, since the cache is read-only.
- Reset: all valid bits clear, state goes to IDLE, `addr_q` is zeroed, and every output is 0. A reset during FILL abandons the fill: the line is not written, and `pmem_read` is 0 from the cycle after the reset edge. A late `pmem_resp` arriving in IDLE is ignored.
- `rdata_a` is 0 whenever `resp_a`=0.

## Timing
- Hit: request sampled at edge N, so `resp_a` is high in cycle N+1. The next request can be accepted at edge N+2, giving one word per 2 cycles.
- Miss: request sampled at edge N. `pmem_read` rises in cycle N+1 and holds through the `pmem_resp` cycle M. RESPOND is cycle M+1, with `resp_a` high in M+1.
- Miss latency is therefore memory latency + 2 cycles.
- `pmem_read` is decoded from state and is low in cycle M+1.
- `pmem_address` and `pmem_read` are stable throughout FILL.

## Structure
- Shared types in `rv32i_types`:
  - `rv32i_word`.
  - new `rv32i_line` (256-bit typedef).
  - constants `LINE_OFFSET_BITS`=5 and `WORD_SEL_MSB`=4.
- Sub-module `icache_array`: valid, tag, and data storage; combinational read by index; synchronous write with load; valid bits cleared by `reset`.
- The top level contains the FSM, `addr_q`, the hit compare, and the word mux.

## Test plan
- Cold miss: read 0x0000_0060. Expect `pmem_read` with `pmem_address`=0x0000_0060. Return a line whose words are 0xA0..0xA7. Expect `resp_a` with `rdata_a`=0xA0 exactly one cycle after `pmem_resp`.
- Hit and word select: after the line above is installed, read 0x0000_007C. Expect `resp_a` in the next cycle with `rdata_a`=0xA7 and no `pmem_read`.
- Conflict miss: read 0x0000_0160 (same index 3, tag 1). Expect a fill from 0x0000_0160. Then re-reading 0x0000_0060 misses again.
- Read withdrawn: drop `read_a` during FILL. Expect no `resp_a` pulse. A subsequent read of the same address hits in 1 cycle.
- Reset mid-fill: assert `reset` while `pmem_read`=1. Expect `pmem_read`=0 in the following cycle, and a late `pmem_resp` to be ignored. The same address then misses.
- Back-to-back hits: hold `read_a` high with alternating installed addresses. Expect `resp_a` every second cycle with the correct words.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types plus the instruction-cache line geometry and FSM encoding.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] rv32i_line;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int WORD_SEL_MSB     = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESPOND
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side word port and physical-memory line port of the instruction cache.
interface icache_if;
    import rv32i_types::*;

    logic      read_a;
    rv32i_word address_a;
    rv32i_word rdata_a;
    logic      resp_a;
    logic      pmem_read;
    rv32i_word pmem_address;
    rv32i_line pmem_rdata;
    logic      pmem_resp;

    modport slave (
        input  read_a, address_a, pmem_rdata, pmem_resp,
        output rdata_a, resp_a, pmem_read, pmem_address
    );

    modport master (
        output read_a, address_a, pmem_rdata, pmem_resp,
        input  rdata_a, resp_a, pmem_read, pmem_address
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/line storage: combinational read by index, synchronous write on load.
module icache_array
    import rv32i_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [S_INDEX-1:0]                   index,
    input  logic                                 load,
    input  logic [31-LINE_OFFSET_BITS-S_INDEX:0] tag_in,
    input  rv32i_line                            line_in,
    output logic                                 valid,
    output logic [31-LINE_OFFSET_BITS-S_INDEX:0] tag_out,
    output rv32i_line                            line_out
);
    localparam int SETS = 2 ** S_INDEX;

    logic [SETS-1:0]                        valid_q;
    logic [31-LINE_OFFSET_BITS-S_INDEX:0]   tag_q  [SETS];
    rv32i_line                              line_q [SETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (load) begin
            valid_q[index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bit alone guards them.
    always_ff @(posedge clk) begin
        if (load) begin
            tag_q[index]  <= tag_in;
            line_q[index] <= line_in;
        end
    end

    assign valid    = valid_q[index];
    assign tag_out  = tag_q[index];
    assign line_out = line_q[index];

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: IDLE/FILL/RESPOND FSM, request address register, hit compare, word mux.
module icache_responder
    import rv32i_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic     clk,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int TAG_LSB = LINE_OFFSET_BITS + S_INDEX;

    icache_state_e state;
    logic [31:2]   addr_q;

    logic [S_INDEX-1:0]  index;
    logic [31:TAG_LSB]   tag;
    logic                arr_valid;
    logic [31:TAG_LSB]   arr_tag;
    rv32i_line           arr_line;
    logic                hit;
    logic                load;
    logic [2:0]          word_sel;
    logic [7:0]          bit_base;

    // The request is looked up straight off the bus in IDLE; afterwards only the captured address is used.
    always_comb begin
        if (state == IDLE) begin
            index = bus.address_a[TAG_LSB-1:LINE_OFFSET_BITS];
            tag   = bus.address_a[31:TAG_LSB];
        end else begin
            index = addr_q[TAG_LSB-1:LINE_OFFSET_BITS];
            tag   = addr_q[31:TAG_LSB];
        end
    end

    assign hit  = arr_valid && (arr_tag == tag);
    assign load = (state == FILL) && bus.pmem_resp && !reset;

    icache_array #(.S_INDEX(S_INDEX)) u_array (
        .clk      (clk),
        .reset    (reset),
        .index    (index),
        .load     (load),
        .tag_in   (tag),
        .line_in  (bus.pmem_rdata),
        .valid    (arr_valid),
        .tag_out  (arr_tag),
        .line_out (arr_line)
    );

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.read_a) begin
                        addr_q <= bus.address_a[31:2];
                        state  <= hit ? RESPOND : FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) state <= RESPOND;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign word_sel = addr_q[WORD_SEL_MSB:2];
    assign bit_base = {word_sel, 5'b0};

    // A withdrawn request still passes through RESPOND, so the pulse is qualified by read_a.
    assign bus.resp_a       = (state == RESPOND) && bus.read_a;
    assign bus.rdata_a      = bus.resp_a ? arr_line[bit_base +: 32] : '0;
    assign bus.pmem_read    = (state == FILL);
    assign bus.pmem_address = bus.pmem_read ? {addr_q[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}} : '0;

endmodule
